io_block: RTL and testbench



---
 rtl/io_block.sv | 126 ++++++++++++
 tb/tb_io_block.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_block.sv
`default_nettype none
// ============================================================================
// Module   : io_block
// Purpose  : Configurable fabric-edge I/O block. External input pins drive
//            any subset of the single/double/global routing tracks through
//            tristate buffers. Each external output pin reads one track
//            through a priority mux. A flat configuration vector programs
//            both directions.
// Ports    : clk             - clock (used only when REG_OUT=1)
//            rst_n           - async active-low reset (used only when REG_OUT=1)
//            single          - WS single-length tracks (bidirectional)
//            double          - WD double-length tracks (bidirectional)
//            global_trk      - WG global tracks (bidirectional); named this
//                              way because `global` is a reserved word
//            external_input  - EXTIN pins entering the fabric
//            external_output - EXTOUT pins leaving the fabric
//            c               - (EXTIN+EXTOUT)*(WS+WD+WG) configuration bits
// Revision : 1.0 - initial release
// ============================================================================
module io_block #(
  parameter int WS      = 7,
  parameter int WD      = 6,
  parameter int WG      = 3,
  parameter int EXTIN   = 5,
  parameter int EXTOUT  = 2,
  parameter int REG_OUT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  inout  wire  [WS-1:0]                          single,
  inout  wire  [WD-1:0]                          double,
  inout  wire  [WG-1:0]                          global_trk,
  input  logic [EXTIN-1:0]                       external_input,
  output logic [EXTOUT-1:0]                      external_output,
  input  logic [(EXTIN+EXTOUT)*(WS+WD+WG)-1:0]   c
);

  // Segment width: one bit per track, singles first, then doubles, globals.
  localparam int N = WS + WD + WG;

  // --------------------------------------------------------------------------
  // Input path: gather, per track, whether any enabled input drives a 1 and
  // whether any enabled input drives a 0. Both set means two inputs disagree
  // on the same track, which is contention and resolves to X.
  // --------------------------------------------------------------------------
  logic [N-1:0] trk_hi;
  logic [N-1:0] trk_lo;
  logic [N-1:0] trk_en;

  always_comb begin
    trk_hi = '0;
    trk_lo = '0;
    for (int i = 0; i < EXTIN; i++) begin
      trk_hi = trk_hi | (c[i*N +: N] & {N{external_input[i]}});
      trk_lo = trk_lo | (c[i*N +: N] & {N{~external_input[i]}});
    end
  end

  assign trk_en = trk_hi | trk_lo;

  // One tristate driver per track bit; high-Z when no input is enabled.
  for (genvar t = 0; t < WS; t++) begin : g_drv_single
    assign single[t] = trk_en[t]
                     ? ((trk_hi[t] & trk_lo[t]) ? 1'bx : trk_hi[t])
                     : 1'bz;
  end

  for (genvar t = 0; t < WD; t++) begin : g_drv_double
    assign double[t] = trk_en[WS+t]
                     ? ((trk_hi[WS+t] & trk_lo[WS+t]) ? 1'bx : trk_hi[WS+t])
                     : 1'bz;
  end

  for (genvar t = 0; t < WG; t++) begin : g_drv_global
    assign global_trk[t] = trk_en[WS+WD+t]
                         ? ((trk_hi[WS+WD+t] & trk_lo[WS+WD+t]) ? 1'bx
                                                                : trk_hi[WS+WD+t])
                         : 1'bz;
  end

  // --------------------------------------------------------------------------
  // Output path: read the resolved track values. Bit order of the read
  // vector matches the segment layout, so the lowest set configuration bit
  // wins, which gives single > double > global, lowest index first.
  // --------------------------------------------------------------------------
  logic [N-1:0]      trk_rd;
  logic [EXTOUT-1:0] ext_out_d;

  assign trk_rd = {global_trk, double, single};

  always_comb begin
    ext_out_d = '0;
    for (int o = 0; o < EXTOUT; o++) begin
      // Walk from the top down so the lowest set bit is the last to assign.
      for (int b = N - 1; b >= 0; b--) begin
        if (c[(EXTIN + o)*N + b]) begin
          ext_out_d[o] = trk_rd[b];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional output register.
  // --------------------------------------------------------------------------
  if (REG_OUT != 0) begin : g_reg_out
    logic [EXTOUT-1:0] ext_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ext_out_q <= '0;
      end else begin
        ext_out_q <= ext_out_d;
      end
    end

    assign external_output = ext_out_q;
  end else begin : g_comb_out
    // Clock and reset have no function in the combinational variant.
    wire unused_clk_rst;
    assign unused_clk_rst  = clk ^ rst_n;
    assign external_output = ext_out_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_io_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_block
// Purpose  : Self-checking bench for io_block. Instance u_comb uses the
//            combinational output path, instance u_reg the registered one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_block;

  localparam int WS     = 7;
  localparam int WD     = 6;
  localparam int WG     = 3;
  localparam int EXTIN  = 5;
  localparam int EXTOUT = 2;
  localparam int N      = WS + WD + WG;
  localparam int CW     = (EXTIN + EXTOUT) * N;

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // ---------------- combinational instance ----------------
  wire  [WS-1:0]     s0;
  wire  [WD-1:0]     d0;
  wire  [WG-1:0]     g0;
  logic [WS-1:0]     tb_s0 = '0;
  logic [WD-1:0]     tb_d0 = '0;
  logic [WG-1:0]     tb_g0 = '0;
  logic              tb_en0 = 1'b0;
  logic [EXTIN-1:0]  ein0 = '0;
  logic [EXTOUT-1:0] eout0;
  logic [CW-1:0]     c0 = '0;

  assign s0 = tb_en0 ? tb_s0 : {WS{1'bz}};
  assign d0 = tb_en0 ? tb_d0 : {WD{1'bz}};
  assign g0 = tb_en0 ? tb_g0 : {WG{1'bz}};

  io_block #(.WS(WS), .WD(WD), .WG(WG), .EXTIN(EXTIN), .EXTOUT(EXTOUT),
             .REG_OUT(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .single(s0), .double(d0), .global_trk(g0),
    .external_input(ein0), .external_output(eout0), .c(c0));

  // ---------------- registered instance ----------------
  wire  [WS-1:0]     s1;
  wire  [WD-1:0]     d1;
  wire  [WG-1:0]     g1;
  logic [WS-1:0]     tb_s1 = '0;
  logic [EXTIN-1:0]  ein1 = '0;
  logic [EXTOUT-1:0] eout1;
  logic [CW-1:0]     c1 = '0;

  assign s1 = tb_s1;
  assign d1 = '0;
  assign g1 = '0;

  io_block #(.WS(WS), .WD(WD), .WG(WG), .EXTIN(EXTIN), .EXTOUT(EXTOUT),
             .REG_OUT(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .single(s1), .double(d1), .global_trk(g1),
    .external_input(ein1), .external_output(eout1), .c(c1));

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference for one output pin: first enabled single, else first enabled
  // double, else first enabled global, else 0.
  function automatic logic ref_out(input logic [N-1:0] seg,
                                   input logic [WS-1:0] s,
                                   input logic [WD-1:0] d,
                                   input logic [WG-1:0] g);
    for (int j = 0; j < WS; j++) if (seg[j])       return s[j];
    for (int j = 0; j < WD; j++) if (seg[WS+j])    return d[j];
    for (int j = 0; j < WG; j++) if (seg[WS+WD+j]) return g[j];
    return 1'b0;
  endfunction

  // Read one track of u_comb by type (0 single, 1 double, 2 global).
  function automatic logic rd_trk(input int typ, input int idx);
    if (typ == 0) return s0[idx];
    if (typ == 1) return d0[idx];
    return g0[idx];
  endfunction

  initial begin
    int typ_w[3];
    int typ_off[3];
    typ_w   = '{WS, WD, WG};
    typ_off = '{0, WS, WS + WD};

    // ---------- reset state of the registered instance ----------
    c1    = '0;
    c1[EXTIN*N + 0] = 1'b1;       // output 0 <- single[0]
    tb_s1 = 7'h01;
    #3;
    check_val("reg_reset_hold", 32'(eout1), 32'h0);

    // ---------- input to single ----------
    tb_en0 = 1'b0;
    c0 = '0; c0[3] = 1'b1; ein0 = 5'b00001; #1;
    check_val("in_single_hi", 32'(s0[3]), 32'h1);
    ein0 = 5'b00000; #1;
    check_val("in_single_lo", 32'(s0[3]), 32'h0);

    // ---------- input to double / global ----------
    c0 = '0; c0[2*N + 7 + 4] = 1'b1; c0[4*N + 13 + 1] = 1'b1;
    ein0 = 5'b10100; #1;
    check_val("in_double4", 32'(d0[4]), 32'h1);
    check_val("in_global1", 32'(g0[1]), 32'h1);
    ein0 = 5'b00100; #1;
    check_val("in_global1_lo", 32'(g0[1]), 32'h0);
    check_val("in_double4_hold", 32'(d0[4]), 32'h1);

    // ---------- output from track ----------
    tb_en0 = 1'b1; tb_s0 = 7'h55; tb_d0 = 6'h2A; tb_g0 = 3'b101; ein0 = '0;
    c0 = '0; c0[5*N + 2] = 1'b1; #1;
    check_val("out0_single2", 32'(eout0[0]), 32'h1);
    check_val("out1_unconf", 32'(eout0[1]), 32'h0);
    c0 = '0; c0[6*N + 15] = 1'b1; #1;
    check_val("out1_global2", 32'(eout0[1]), 32'h1);
    check_val("out0_unconf", 32'(eout0[0]), 32'h0);
    c0 = '0; c0[5*N + 7 + 1] = 1'b1; #1;     // double[1] of 2A = 1
    check_val("out0_double1", 32'(eout0[0]), 32'h1);

    // ---------- priority and unconfigured ----------
    c0 = '0; c0[5*N + 1] = 1'b1; c0[5*N + 7] = 1'b1;
    tb_s0 = 7'h02; tb_d0 = 6'h00; #1;
    check_val("prio_single", 32'(eout0[0]), 32'h1);
    tb_s0 = 7'h00; tb_d0 = 6'h01; #1;
    check_val("prio_single_lo", 32'(eout0[0]), 32'h0);
    c0[5*N +: N] = '0; tb_s0 = 7'h7F; tb_d0 = 6'h3F; tb_g0 = 3'h7; #1;
    check_val("unconf_zero", 32'(eout0[0]), 32'h0);

    // ---------- internal loopback ----------
    tb_en0 = 1'b0;
    c0 = '0; c0[0*N + 5] = 1'b1; c0[5*N + 5] = 1'b1;
    ein0 = 5'b00001; #1;
    check_val("loop_hi", 32'(eout0[0]), 32'h1);
    ein0 = 5'b11110; #1;
    check_val("loop_lo", 32'(eout0[0]), 32'h0);

    // ---------- randomized sweep ----------
    for (int r = 0; r < 10; r++) begin
      // inputs: one random track of each type per input
      tb_en0 = 1'b0;
      for (int i = 0; i < EXTIN; i++) begin
        for (int typ = 0; typ < 3; typ++) begin
          int idx;
          idx  = int'($urandom_range(typ_w[typ] - 1, 0));
          c0   = '0;
          c0[i*N + typ_off[typ] + idx] = 1'b1;
          ein0 = 5'($urandom);
          #1;
          check_val($sformatf("rnd_in%0d_t%0d_%0d", i, typ, idx),
                    32'(rd_trk(typ, idx)), 32'(ein0[i]));
        end
      end
      // outputs: one random track of each type, then a random multi-bit seg
      tb_en0 = 1'b1;
      for (int o = 0; o < EXTOUT; o++) begin
        for (int typ = 0; typ < 4; typ++) begin
          logic [N-1:0] seg;
          tb_s0 = 7'($urandom);
          tb_d0 = 6'($urandom);
          tb_g0 = 3'($urandom);
          seg   = '0;
          if (typ < 3) seg[typ_off[typ] + int'($urandom_range(typ_w[typ] - 1, 0))] = 1'b1;
          else         seg = N'($urandom);
          c0 = '0;
          c0[(EXTIN + o)*N +: N] = seg;
          #1;
          check_val($sformatf("rnd_out%0d_t%0d_%0h", o, typ, seg),
                    32'(eout0[o]), 32'(ref_out(seg, tb_s0, tb_d0, tb_g0)));
        end
      end
    end

    // ---------- registered output ----------
    @(negedge clk);
    rst_n = 1'b1; #1;
    check_val("reg_before_edge", 32'(eout1), 32'h0);
    @(posedge clk); #1;
    check_val("reg_after_edge", 32'(eout1), 32'h1);
    @(negedge clk);
    tb_s1 = 7'h00; #1;
    check_val("reg_latency_hold", 32'(eout1), 32'h1);
    @(posedge clk); #1;
    check_val("reg_latency_upd", 32'(eout1), 32'h0);
    @(negedge clk);
    tb_s1 = 7'h01;
    @(posedge clk); #1;
    check_val("reg_set_again", 32'(eout1), 32'h1);
    #1 rst_n = 1'b0; #1;
    check_val("reg_async_rst", 32'(eout1), 32'h0);
    @(posedge clk); #1;
    check_val("reg_rst_held", 32'(eout1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
